// File: rtl/multdiv_param.sv
// multdiv_param -- sequential signed multiplier / divider, WIDTH-bit two's complement.
//
// Multiply uses radix-2 Booth, divide uses non-restoring division on magnitudes followed
// by sign correction. One iteration per clock, WIDTH iterations per operation.
//
// Optional feature: define MULTDIV_HI_EN to add data_result_hi (high product / remainder).
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   data_operandA   multiplicand / dividend, sampled on the start edge
//   data_operandB   multiplier / divisor, sampled on the start edge
//   ctrl_MULT       start multiply (wins over ctrl_DIV)
//   ctrl_DIV        start divide
//   data_result     low product / quotient, held until the next completion
//   data_exception  overflow / divide-by-zero flag, held with data_result
//   data_resultRDY  one-cycle completion pulse
//   busy            high from the start edge through the RDY cycle
//   data_result_hi  (MULTDIV_HI_EN only) high product / remainder

module multdiv_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
`ifdef MULTDIV_HI_EN
   ,
   output logic [WIDTH-1:0] data_result_hi
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   // Upper part is WIDTH+1 bits so Booth partial sums and doubled remainders never overflow.
   localparam int unsigned AW = 2 * WIDTH + 2;
   localparam logic [CW-1:0]    CntLast = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // acc layout: [AW-1:WIDTH+1] upper (product high / remainder),
   //             [WIDTH:1] lower (multiplier / quotient), [0] Booth guard bit.
   logic [AW-1:0]    acc_q, acc_d, acc_step;
   logic [WIDTH-1:0] a_q, b_q;
   logic             div_q, dz_q;
   logic             start, load_res;

   logic [WIDTH:0]     upper, sum, shifted, rem_step, div_mag;
   logic [WIDTH-1:0]   a_in_mag, b_mag, quo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fin_res;
   logic               fin_exc;

   assign start    = ctrl_MULT | ctrl_DIV;
   assign a_in_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign b_mag    = b_q[WIDTH-1] ? -b_q : b_q;
   assign div_mag  = {1'b0, b_mag};
   assign upper    = acc_q[AW-1:WIDTH+1];

   // One iteration of the selected algorithm.
   always_comb begin
      sum      = upper;
      shifted  = '0;
      rem_step = '0;
      if (!div_q) begin
         case (acc_q[1:0])
            2'b01:   sum = upper + {a_q[WIDTH-1], a_q};
            2'b10:   sum = upper - {a_q[WIDTH-1], a_q};
            default: sum = upper;
         endcase
         acc_step = {sum[WIDTH], sum, acc_q[WIDTH:1]};
      end else begin
         shifted  = {upper[WIDTH-1:0], acc_q[WIDTH]};
         rem_step = upper[WIDTH] ? shifted + div_mag : shifted - div_mag;
         acc_step = {rem_step, acc_q[WIDTH-1:1], ~rem_step[WIDTH], 1'b0};
      end
   end

   assign prod = acc_step[2*WIDTH:1];
   assign quo  = acc_step[WIDTH:1];

   // Final result, valid on the last iteration (or the divide-by-zero shortcut).
   always_comb begin
      fin_res = '0;
      fin_exc = 1'b0;
      if (dz_q) begin
         fin_res = '0;
         fin_exc = 1'b1;
      end else if (!div_q) begin
         fin_res = prod[WIDTH-1:0];
         fin_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      end else begin
         fin_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo : quo;
         fin_exc = (a_q == MinVal) && (&b_q);
      end
   end

`ifdef MULTDIV_HI_EN
   logic [WIDTH:0]   rem_fix;
   logic [WIDTH-1:0] fin_hi;

   always_comb begin
      // Non-restoring leaves a negative remainder one divisor short; restore it once.
      rem_fix = acc_step[AW-1:WIDTH+1];
      if (rem_fix[WIDTH]) begin
         rem_fix = rem_fix + div_mag;
      end
      if (dz_q) begin
         fin_hi = a_q;
      end else if (!div_q) begin
         fin_hi = prod[2*WIDTH-1:WIDTH];
      end else begin
         fin_hi = a_q[WIDTH-1] ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
      end
   end
`endif

   // Next state; a start in any state (re)launches an operation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      load_res = 1'b0;
      if (start) begin
         state_d = StRun;
         cnt_d   = '0;
         acc_d   = ctrl_MULT ? {{(WIDTH + 1){1'b0}}, data_operandB, 1'b0}
                             : {{(WIDTH + 1){1'b0}}, a_in_mag, 1'b0};
      end else begin
         case (state_q)
            StRun: begin
               if (dz_q) begin
                  state_d  = StDone;
                  load_res = 1'b1;
               end else begin
                  acc_d = acc_step;
                  if (cnt_q == CntLast) begin
                     state_d  = StDone;
                     load_res = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         acc_q          <= '0;
         a_q            <= '0;
         b_q            <= '0;
         div_q          <= 1'b0;
         dz_q           <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
`ifdef MULTDIV_HI_EN
         data_result_hi <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (start) begin
            a_q   <= data_operandA;
            b_q   <= data_operandB;
            div_q <= !ctrl_MULT;
            dz_q  <= !ctrl_MULT && (data_operandB == '0);
         end
         if (load_res) begin
            data_result    <= fin_res;
            data_exception <= fin_exc;
`ifdef MULTDIV_HI_EN
            data_result_hi <= fin_hi;
`endif
         end
      end
   end

   assign data_resultRDY = (state_q == StDone);
   assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_param.sv
`timescale 1ns/1ps

module tb_multdiv_param;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic [31:0] a32, b32, res32;
   logic        mult32, div32, exc32, rdy32, busy32;
   logic [7:0]  a8, b8, res8;
   logic        mult8, div8, exc8, rdy8, busy8;
`ifdef MULTDIV_HI_EN
   logic [31:0] hi32;
   logic [7:0]  hi8;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   multdiv_param #(.WIDTH(32)) dut32 (
      .clock(clock), .reset_n(reset_n), .data_operandA(a32), .data_operandB(b32),
      .ctrl_MULT(mult32), .ctrl_DIV(div32), .data_result(res32), .data_exception(exc32),
      .data_resultRDY(rdy32), .busy(busy32)
`ifdef MULTDIV_HI_EN
      , .data_result_hi(hi32)
`endif
   );

   multdiv_param #(.WIDTH(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .data_operandA(a8), .data_operandB(b8),
      .ctrl_MULT(mult8), .ctrl_DIV(div8), .data_result(res8), .data_exception(exc8),
      .data_resultRDY(rdy8), .busy(busy8)
`ifdef MULTDIV_HI_EN
      , .data_result_hi(hi8)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] get_res(input bit w8);
      return w8 ? 64'(res8) : 64'(res32);
   endfunction
   function automatic logic [63:0] get_exc(input bit w8);
      return w8 ? 64'(exc8) : 64'(exc32);
   endfunction
   function automatic logic [63:0] get_rdy(input bit w8);
      return w8 ? 64'(rdy8) : 64'(rdy32);
   endfunction
   function automatic logic [63:0] get_busy(input bit w8);
      return w8 ? 64'(busy8) : 64'(busy32);
   endfunction
`ifdef MULTDIV_HI_EN
   function automatic logic [63:0] get_hi(input bit w8);
      return w8 ? 64'(hi8) : 64'(hi32);
   endfunction
`endif

   // Reference: plain signed arithmetic on sign-extended 64-bit values.
   function automatic void model(input bit is_div, input int w, input longint a, input longint b,
                                 output logic [63:0] res, output logic [63:0] exc,
                                 output logic [63:0] hi);
      longint mask = (longint'(1) << w) - 1;
      longint minv = -(longint'(1) << (w - 1));
      longint p;
      if (!is_div) begin
         p   = a * b;
         res = 64'(p & mask);
         hi  = 64'((p >>> w) & mask);
         exc = 64'((p < minv) || (p > -minv - 1));
      end else if (b == 0) begin
         res = 0; exc = 1; hi = 64'(a & mask);
      end else if (a == minv && b == -1) begin
         res = 64'(a & mask); exc = 1; hi = 0;
      end else begin
         res = 64'((a / b) & mask); hi = 64'((a % b) & mask); exc = 0;
      end
   endfunction

   task automatic start_op(input bit w8, input bit is_div, input logic [31:0] a,
                           input logic [31:0] b);
      @(negedge clock);
      if (w8) begin
         a8 = a[7:0]; b8 = b[7:0]; mult8 = !is_div; div8 = is_div;
      end else begin
         a32 = a; b32 = b; mult32 = !is_div; div32 = is_div;
      end
      @(posedge clock); #1;
      mult8 = 1'b0; div8 = 1'b0; mult32 = 1'b0; div32 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
   endtask

   // Counts edges after the start edge until RDY; bounded.
   task automatic wait_rdy(input bit w8, output int n, output bit busy_ok);
      n = 0;
      busy_ok = 1'b1;
      while (get_rdy(w8) !== 64'd1 && n < 200) begin
         if (get_busy(w8) !== 64'd1) busy_ok = 1'b0;
         @(posedge clock); #1;
         n++;
      end
      if (get_busy(w8) !== 64'd1) busy_ok = 1'b0;
   endtask

   task automatic check_result(input string tag, input bit w8, input bit is_div,
                               input logic [31:0] a, input logic [31:0] b);
      logic [63:0] er, ee, eh;
      longint sa, sb;
      sa = w8 ? longint'($signed(a[7:0])) : longint'($signed(a));
      sb = w8 ? longint'($signed(b[7:0])) : longint'($signed(b));
      model(is_div, w8 ? 8 : 32, sa, sb, er, ee, eh);
      check({tag, "_res"}, get_res(w8), er);
      check({tag, "_exc"}, get_exc(w8), ee);
`ifdef MULTDIV_HI_EN
      check({tag, "_hi"}, get_hi(w8), eh);
`endif
   endtask

   task automatic run_op(input string tag, input bit w8, input bit is_div,
                         input logic [31:0] a, input logic [31:0] b);
      int n, exp_lat;
      bit bok, dz;
      dz = is_div && (w8 ? (b[7:0] == 8'd0) : (b == 32'd0));
      exp_lat = dz ? 1 : (w8 ? 8 : 32);
      start_op(w8, is_div, a, b);
      wait_rdy(w8, n, bok);
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_busy"}, 64'(bok), 64'd1);
      check_result(tag, w8, is_div, a, b);
      @(posedge clock); #1;
      check({tag, "_rdy_off"}, get_rdy(w8), 64'd0);
      check({tag, "_busy_off"}, get_busy(w8), 64'd0);
      check_result({tag, "_hold"}, w8, is_div, a, b);
   endtask

   initial begin
      int n;
      bit bok, saw;
      logic [31:0] ra, rb;
      bit rd;

      reset_n = 1'b0;
      a32 = '0; b32 = '0; mult32 = 1'b0; div32 = 1'b0;
      a8 = '0; b8 = '0; mult8 = 1'b0; div8 = 1'b0;
      #12;
      check("rst_res", get_res(0), 64'd0);
      check("rst_exc", get_exc(0), 64'd0);
      check("rst_rdy", get_rdy(0), 64'd0);
      check("rst_busy", get_busy(0), 64'd0);
      check("rst_rdy8", get_rdy(1), 64'd0);
`ifdef MULTDIV_HI_EN
      check("rst_hi", get_hi(0), 64'd0);
`endif
      reset_n = 1'b1;

      run_op("mul_7_m6", 0, 0, 32'd7, -32'sd6);
      check("mul_7_m6_const", get_res(0), 64'hFFFF_FFD6);
      run_op("mul_ovf", 0, 0, 32'h4000_0000, 32'd4);
      check("mul_ovf_exc_const", get_exc(0), 64'd1);
      run_op("div_m100_7", 0, 1, -32'sd100, 32'd7);
      check("div_m100_7_const", get_res(0), 64'hFFFF_FFF2);
      run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_by0", 0, 1, 32'd123, 32'd0);
      run_op("mul8_min_m1", 1, 0, 32'h80, 32'hFF);
      check("mul8_const", get_res(1), 64'h80);
      run_op("div8_min_m1", 1, 1, 32'h80, 32'hFF);

      // Start coinciding with the RDY cycle keeps busy high.
      start_op(0, 0, 32'd3, 32'd5);
      wait_rdy(0, n, bok);
      check("b2b_first_lat", 64'(n), 64'd32);
      start_op(0, 1, 32'd20, 32'd4);
      check("b2b_busy", get_busy(0), 64'd1);
      check("b2b_rdy", get_rdy(0), 64'd0);
      wait_rdy(0, n, bok);
      check("b2b_lat", 64'(n), 64'd32);
      check_result("b2b", 0, 1, 32'd20, 32'd4);

      // Abort: DIV issued 10 edges after MULT; only one RDY.
      start_op(0, 0, 32'd3, 32'd5);
      saw = 1'b0;
      repeat (9) begin
         if (get_rdy(0) !== 64'd0) saw = 1'b1;
         @(posedge clock); #1;
      end
      start_op(0, 1, 32'd20, 32'd4);
      wait_rdy(0, n, bok);
      check("abort_no_rdy", 64'(saw), 64'd0);
      check("abort_lat", 64'(n), 64'd32);
      check("abort_res", get_res(0), 64'd5);
      check("abort_exc", get_exc(0), 64'd0);

      // Reset mid-run.
      start_op(0, 0, 32'd9, 32'd9);
      repeat (5) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_res", get_res(0), 64'd0);
      check("mid_rst_exc", get_exc(0), 64'd0);
      check("mid_rst_rdy", get_rdy(0), 64'd0);
      check("mid_rst_busy", get_busy(0), 64'd0);
      #3 reset_n = 1'b1;
      saw = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (get_rdy(0) !== 64'd0 || get_busy(0) !== 64'd0) saw = 1'b1;
      end
      check("mid_rst_quiet", 64'(saw), 64'd0);

      // Random operations on both widths.
      for (int i = 0; i < 24; i++) begin
         rd = 1'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($signed(8'($urandom)));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rnd32_%0d", i), 0, rd, ra, rb);
         run_op($sformatf("rnd8_%0d", i), 1, rd, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
